// File: rtl/reg_dump_reader_if.sv
// Word stream carrying one (address, value) register pair per transfer.
// The master presents out_valid/out_addr/out_data/out_last; the slave answers with out_ready.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Debug readout engine: sweeps every register through a spare read port and streams
// (address, value) pairs, keeping each word coherent with writes snooped from the write port.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  reg_dump_reader_if.master out_if
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] word_data;
  logic              word_last;
  logic              done_q;

  logic              load_hit;
  logic              hold_hit;
  logic              accept;

  // The register file commits a write on the same edge we capture, so a write to
  // the address being loaded or held must override the value we would otherwise keep.
  assign load_hit = rf_we && (rf_waddr == ptr);
  assign hold_hit = rf_we && (rf_waddr == word_addr);
  assign accept   = (state == HOLD) && out_if.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = abort ? IDLE : HOLD;
      end
      HOLD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (accept) begin
          next_state = word_last ? IDLE : LOAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Word register, sweep pointer and completion pulse; abort discards the held word
  // even when the consumer is ready on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      word_addr <= '0;
      word_data <= '0;
      word_last <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            ptr <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            ptr       <= '0;
            word_last <= 1'b0;
          end else begin
            word_addr <= ptr;
            word_last <= (ptr == LAST_ADDR);
            word_data <= load_hit ? rf_wdata : rf_data;
          end
        end
        HOLD: begin
          if (abort) begin
            ptr       <= '0;
            word_last <= 1'b0;
          end else if (accept) begin
            if (word_last) begin
              word_last <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end else if (hold_hit) begin
            word_data <= rf_wdata;
          end
        end
        default: begin
          ptr <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rf_addr          = (state == IDLE) ? '0 : ptr;
    busy             = (state != IDLE);
    done             = done_q;
    out_if.out_valid = (state == HOLD);
    out_if.out_addr  = word_addr;
    out_if.out_data  = word_data;
    out_if.out_last  = word_last;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: stimulus pushes expected words into a queue and
// an independent monitor pops and compares them as the stream is accepted.
module tb_reg_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] regs [NUM_REGS];

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  reg_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  reg_dump_reader #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .busy    (busy),
    .done    (done),
    .out_if  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on the rising edge, preload on reset.
  assign rf_data = regs[rf_addr];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h1000_0000 + 32'(i);
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start         = s;
    abort         = a;
    dif.out_ready = r;
  endtask

  task automatic pushWord(input int i, input logic [31:0] d);
    exp_t e;
    e.addr = ADDR_W'(i);
    e.data = d;
    e.last = (i == NUM_REGS - 1);
    expq.push_back(e);
  endtask

  // phase 0: pristine regs; phase 1: regs after the second dump's writes landed
  function automatic logic [31:0] expData(input int i, input int phase, input bit dump2);
    logic [31:0] d;
    d = 32'h1000_0000 + 32'(i);
    if (dump2) begin
      if (i == 5) d = 32'hCAFE_0005;
      if (i == 7) d = 32'hDEAD_BEEF;
      if (i == 9) d = 32'h9999_0009;
    end
    if (phase == 1) begin
      if (i == 1) d = 32'h1111_0001;
      if (i == 5) d = 32'hCAFE_0005;
      if (i == 7) d = 32'hDEAD_BEEF;
      if (i == 9) d = 32'h9999_0009;
    end
    return d;
  endfunction

  task automatic waitWord(input int a);
    int n = 0;
    while (!(dif.out_valid && dif.out_addr == ADDR_W'(a)) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("reach_addr_%0d", a), 32'(n < 300), 32'd1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b1, 1'b0, dif.out_ready);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, dif.out_ready);
  endtask

  // Monitor: an edge with valid and ready (and no abort/reset) consumes one word.
  always @(negedge clk) begin
    if (!reset && dif.out_valid && dif.out_ready && !abort) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_word_addr", 32'(dif.out_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput($sformatf("word_addr_%0d", e.addr), 32'(dif.out_addr), 32'(e.addr));
        checkOutput($sformatf("word_data_%0d", e.addr), dif.out_data, e.data);
        checkOutput($sformatf("word_last_%0d", e.addr), 32'(dif.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    int cnt;
    reset    = 1'b1;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(dif.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_data", dif.out_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] full dump with ready tied high");
    for (int i = 0; i < NUM_REGS; i++) pushWord(i, expData(i, 0, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("valid_in_load", 32'(dif.out_valid), 32'd0);
    cnt = 0;
    while (!done && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("done_cycle", 32'(cnt), 32'd64);
    checkOutput("busy_with_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("dump1_drained", 32'(expq.size()), 32'd0);

    $display("[TB] backpressure, forwarding and snoop");
    for (int i = 0; i < NUM_REGS; i++) pushWord(i, expData(i, 0, 1'b1));
    pulseStart();
    waitWord(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rf_we    = (i < 2);
      rf_waddr = (i == 0) ? 5'd1 : 5'd9;
      rf_wdata = (i == 0) ? 32'h1111_0001 : 32'h9999_0009;
      @(posedge clk); #1;
      checkOutput("bp_valid", 32'(dif.out_valid), 32'd1);
      checkOutput("bp_addr", 32'(dif.out_addr), 32'd3);
      checkOutput("bp_data", dif.out_data, 32'h1000_0003);
    end
    rf_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitWord(4);
    @(posedge clk); #1;
    rf_we    = 1'b1;
    rf_waddr = 5'd5;
    rf_wdata = 32'hCAFE_0005;
    @(posedge clk); #1;
    rf_we = 1'b0;
    waitWord(7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rf_we    = 1'b1;
    rf_waddr = 5'd7;
    rf_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rf_we = 1'b0;
    checkOutput("snoop_data", dif.out_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone();
    @(posedge clk); #1;
    checkOutput("dump2_drained", 32'(expq.size()), 32'd0);

    $display("[TB] abort while holding addr 10");
    for (int i = 0; i < 10; i++) pushWord(i, expData(i, 1, 1'b0));
    pulseStart();
    waitWord(10);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_valid", 32'(dif.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_last", 32'(dif.out_last), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done), 32'd0);
    checkOutput("dump3_drained", 32'(expq.size()), 32'd0);

    $display("[TB] restart, ignored start, async reset at addr 12");
    for (int i = 0; i < 12; i++) pushWord(i, expData(i, 1, 1'b0));
    pulseStart();
    waitWord(0);
    waitWord(6);
    pulseStart();
    waitWord(12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(dif.out_valid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_addr", 32'(dif.out_addr), 32'd0);
    checkOutput("arst_data", dif.out_data, 32'd0);
    checkOutput("arst_rf_addr", 32'(rf_addr), 32'd0);
    checkOutput("dump4_drained", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_done", 32'(done), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("start_abort_valid", 32'(dif.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
